inst_ram_loader: RTL and testbench
==================================

Name: inst_ram_loader

Overview:
- Write-side companion of the byte-wide instruction RAM: accepts 32-bit instruction words over a valid/ready stream and writes each word into RAM as four consecutive byte writes, little endian (byte 0 = bits 7:0 at lowest address).
- Sits between the boot/debug link and the instruction RAM write port.
- Asserts core_hold while loading so the fetch path cannot read a partially written program.

Parameters:
- INST_DEPTH, 1024, RAM depth in bytes; power of two; AW = clog2(INST_DEPTH).
- INST_MEM_WIDTH, 8, RAM word width in bits; fixed at 8.
- INST_WIDTH, 32, stream word width in bits; fixed at 32.
- CW, clog2(INST_DEPTH/4)+1, width of the word counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle load request; sampled only in IDLE.
- base_addr  input  AW  first byte address; must be 4-byte aligned.
- word_count  input  CW  number of 32-bit words to load.
- s_valid  input  1  stream word valid.
- s_data  input  32  stream instruction word.
- s_ready  output  1  loader can accept a word.
- mem_addr  output  AW  RAM byte address.
- mem_din  output  8  RAM write data.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- busy  output  1  load in progress.
- core_hold  output  1  equals busy; holds the core in reset.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  sticky range/alignment error.

Behaviour:
- Reset value 0 for all outputs, state, counters and the word register. Reset applies immediately and asynchronously, including mid-load. Bytes already written stay in RAM. No done pulse is issued for an aborted load.
- States: IDLE, WAIT_WORD, WRITE, FINISH.
- IDLE, start=1, checks:
  - base_addr[1:0]!=0, or base_addr + 4*word_count > INST_DEPTH (computed at AW+CW+2 bits, so no wrap): set err, stay IDLE, no writes.
  - word_count==0: go to FINISH, no writes.
  - Otherwise: latch cur_addr=base_addr and remaining=word_count, clear err, go to WAIT_WORD.
- start outside IDLE: ignored.
- busy=1 in WAIT_WORD, WRITE and FINISH.
- WAIT_WORD:
  - s_ready=1.
  - On s_valid&s_ready: capture s_data, set byte_idx=0, go to WRITE.
  - s_valid without ready is held by the source (standard valid/ready; data stable until accepted).
- WRITE (exactly 4 cycles):
  - Each cycle: mem_en=mem_we=1, mem_addr=cur_addr, mem_din=word[8*byte_idx+7 : 8*byte_idx]. At the clock edge, cur_addr+=1 and byte_idx+=1.
  - After byte_idx==3: remaining-=1. If remaining was 1, go to FINISH; else go to WAIT_WORD.
  - s_ready=0.
- mem_en=mem_we=0 in every state other than WRITE. The RAM read port is free for external use while not busy.
- FINISH: done=1 for one cycle, then go to IDLE. core_hold drops in the same cycle done drops.
- Timing:
  - A word accepted at edge N is written on cycles N+1..N+4.
  - s_ready reasserts in cycle N+5.
  - Throughput is one word per 5 cycles minimum.
- Address wrap cannot occur: the range check is done up front.
- Top word: base_addr=INST_DEPTH-4 with word_count=1 is legal and writes the last four bytes.

Test Plan:
- Reset, then start with base_addr=0x000, word_count=2, stream 0x00500093 then 0x00A00113 -> writes 93,00,50,00 to 0x000–0x003 and 13,01,A0,00 to 0x004–0x007. done pulses once. busy/core_hold high from the cycle after start through the done cycle.
- Back-pressure: s_valid low for 3 cycles between words -> loader waits in WAIT_WORD with s_ready=1 and mem_we=0. Resulting RAM contents are identical to the first test.
- Error: base_addr=0x002, then a second start with base_addr=0x3FC, word_count=2 (INST_DEPTH=1024) -> err=1 after each, no mem_we. A following valid start with base_addr=0x3FC, word_count=1 clears err and writes 0x3FC–0x3FF.
- word_count=0 -> no writes. done pulses 1 cycle after start. busy high for exactly 1 cycle.
- Assert rst while in WRITE after byte 1 of word 0xDEADBEEF -> all outputs 0 immediately, no done. Only 0xEF and 0xBE are written. A new load then completes normally.
- start pulsed during an active load -> ignored. The current load finishes with its original base_addr and word_count.

Source files
------------

// File: rtl/inst_ram_loader.sv
// rtl/inst_ram_loader.sv - stream-to-byte-RAM instruction loader
// Unpacks 32-bit stream words into four little-endian byte writes and holds the core while loading.
module inst_ram_loader #(
    parameter int INST_DEPTH     = 1024,
    parameter int INST_MEM_WIDTH = 8,
    parameter int INST_WIDTH     = 32,
    parameter int AW             = $clog2(INST_DEPTH),
    parameter int CW             = $clog2(INST_DEPTH / 4) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [CW-1:0]             word_count,
    input  logic                      s_valid,
    input  logic [INST_WIDTH-1:0]     s_data,
    output logic                      s_ready,
    output logic [AW-1:0]             mem_addr,
    output logic [INST_MEM_WIDTH-1:0] mem_din,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic                      busy,
    output logic                      core_hold,
    output logic                      done,
    output logic                      err
);

    localparam int EW = AW + CW + 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t                state;
    logic [AW-1:0]         cur_addr;
    logic [CW-1:0]         remaining;
    logic [INST_WIDTH-1:0] word;
    logic [1:0]            byte_idx;
    logic [1:0]            nxt_idx;
    logic [EW-1:0]         range_end;
    logic                  bad_req;

    // Wide enough that the end-of-range sum can never wrap.
    assign range_end = EW'(base_addr) + (EW'(word_count) << 2);
    assign bad_req   = (base_addr[1:0] != 2'b00) || (range_end > EW'(INST_DEPTH));
    assign nxt_idx   = byte_idx + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            word      <= '0;
            byte_idx  <= '0;
            s_ready   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_req) begin
                            err <= 1'b1;
                        end else if (word_count == '0) begin
                            state     <= FINISH;
                            busy      <= 1'b1;
                            core_hold <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            cur_addr  <= base_addr;
                            remaining <= word_count;
                            err       <= 1'b0;
                            state     <= WAIT_WORD;
                            busy      <= 1'b1;
                            core_hold <= 1'b1;
                            s_ready   <= 1'b1;
                        end
                    end
                end
                WAIT_WORD: begin
                    if (s_valid && s_ready) begin
                        word     <= s_data;
                        byte_idx <= 2'd0;
                        state    <= WRITE;
                        s_ready  <= 1'b0;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= cur_addr;
                        mem_din  <= s_data[INST_MEM_WIDTH-1:0];
                    end
                end
                WRITE: begin
                    cur_addr <= cur_addr + AW'(1);
                    byte_idx <= nxt_idx;
                    if (byte_idx == 2'd3) begin
                        remaining <= remaining - CW'(1);
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        if (remaining == CW'(1)) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state   <= WAIT_WORD;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        // Outputs are registered, so present the next byte one edge ahead.
                        mem_addr <= cur_addr + AW'(1);
                        mem_din  <= word[{nxt_idx, 3'b000} +: INST_MEM_WIDTH];
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    core_hold <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_ram_loader.sv
// tb/tb_inst_ram_loader.sv - directed self-checking bench for inst_ram_loader
module tb_inst_ram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [8:0]  word_count;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_din;
    logic        mem_en;
    logic        mem_we;
    logic        busy;
    logic        core_hold;
    logic        done;
    logic        err;

    logic [7:0]  ram [0:1023];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    inst_ram_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .busy       (busy),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_din;
            wr_cnt        <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    endfunction

    task automatic do_start(input logic [9:0] b, input logic [8:0] wc);
        start      = 1'b1;
        base_addr  = b;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, output int waited);
        s_valid = 1'b1;
        s_data  = d;
        waited  = 0;
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, {30'd0, busy, core_hold}, 32'd3);
        @(negedge clk);
        check({tag, "_after_done"}, {29'd0, done, busy, core_hold}, 32'd0);
    endtask

    initial begin
        int w;
        int wc0;
        int dc0;
        logic [7:0] old_a;
        logic [7:0] old_b;

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        s_valid = 1'b0; s_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {24'd0, s_ready, mem_en, mem_we, busy, core_hold, done, err, 1'b0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic two-word load with latency check
        wc0 = wr_cnt; dc0 = done_cnt;
        do_start(10'h000, 9'd2);
        check("t1_busy_after_start", {29'd0, busy, core_hold, s_ready}, 32'd7);
        send_word(32'h00500093, w);
        check("t1_first_byte", {13'd0, mem_en, mem_we, mem_addr, mem_din}, {13'd0, 2'b11, 10'h000, 8'h93});
        send_word(32'h00A00113, w);
        check("t1_ready_latency", 32'(w), 32'd4);
        wait_done("t1");
        check("t1_word0", ram_word(0), 32'h00500093);
        check("t1_word1", ram_word(4), 32'h00A00113);
        check("t1_writes", 32'(wr_cnt - wc0), 32'd8);
        check("t1_done_count", 32'(done_cnt - dc0), 32'd1);

        // Back-pressure between words
        wc0 = wr_cnt;
        do_start(10'h000, 9'd2);
        send_word(32'h00500093, w);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("t2_stall", {29'd0, s_ready, mem_we, busy}, 32'd5);
            @(negedge clk);
        end
        send_word(32'h00A00113, w);
        wait_done("t2");
        check("t2_word0", ram_word(0), 32'h00500093);
        check("t2_word1", ram_word(4), 32'h00A00113);
        check("t2_writes", 32'(wr_cnt - wc0), 32'd8);

        // Misaligned and out-of-range requests, then the top word
        wc0 = wr_cnt;
        do_start(10'h002, 9'd1);
        check("t3_misaligned", {29'd0, err, busy, s_ready}, 32'd4);
        @(negedge clk);
        do_start(10'h3FC, 9'd2);
        check("t3_overrange", {29'd0, err, busy, s_ready}, 32'd4);
        repeat (3) @(negedge clk);
        check("t3_no_writes", 32'(wr_cnt - wc0), 32'd0);
        do_start(10'h3FC, 9'd1);
        check("t3_err_cleared", {30'd0, err, busy}, 32'd1);
        send_word(32'h11223344, w);
        wait_done("t3");
        check("t3_top_word", ram_word(32'h3FC), 32'h11223344);
        check("t3_writes", 32'(wr_cnt - wc0), 32'd4);

        // Zero-length load
        wc0 = wr_cnt; dc0 = done_cnt;
        do_start(10'h010, 9'd0);
        check("t4_done_busy", {30'd0, done, busy}, 32'd3);
        @(negedge clk);
        check("t4_after", {30'd0, done, busy}, 32'd0);
        check("t4_writes", 32'(wr_cnt - wc0), 32'd0);
        check("t4_done_count", 32'(done_cnt - dc0), 32'd1);

        // Reset in the middle of a word
        wc0 = wr_cnt; dc0 = done_cnt;
        old_a = ram[10'h102];
        do_start(10'h100, 9'd1);
        send_word(32'hDEADBEEF, w);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_async_reset", {15'd0, s_ready, mem_en, mem_we, busy, core_hold, done, err, mem_addr[7:0], mem_din},
              32'd0);
        check("t5_addr_zero", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_writes", 32'(wr_cnt - wc0), 32'd2);
        check("t5_bytes", {16'd0, ram[10'h101], ram[10'h100]}, 32'h0000BEEF);
        check("t5_byte2_untouched", 32'(ram[10'h102]), 32'(old_a));
        check("t5_no_done", 32'(done_cnt - dc0), 32'd0);
        do_start(10'h200, 9'd1);
        send_word(32'hCAFEF00D, w);
        wait_done("t5b");
        check("t5_reload", ram_word(32'h200), 32'hCAFEF00D);

        // start during an active load is ignored
        wc0 = wr_cnt; dc0 = done_cnt;
        old_b = ram[10'h300];
        do_start(10'h020, 9'd2);
        send_word(32'h01234567, w);
        do_start(10'h300, 9'd1);
        send_word(32'h89ABCDEF, w);
        wait_done("t6");
        check("t6_word0", ram_word(32'h020), 32'h01234567);
        check("t6_word1", ram_word(32'h024), 32'h89ABCDEF);
        check("t6_writes", 32'(wr_cnt - wc0), 32'd8);
        check("t6_other_untouched", 32'(ram[10'h300]), 32'(old_b));
        check("t6_done_count", 32'(done_cnt - dc0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
